// File: rtl/pending_priority_encoder.sv
// Sticky pending-request capture with a registered valid/ready priority offer.
// Define PENC_ROUND_ROBIN_EN for round-robin pick; otherwise highest index wins.

module pend_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic grant,
  input  logic clr,
  output logic pending,
  output logic overflow,
  output logic pend_nx
);
  // A re-request in the grant cycle wins over the grant clear.
  assign pend_nx = (pending & ~grant) | req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else if (clr) begin
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      pending  <= pend_nx;
      overflow <= overflow | (req & pending & ~grant);
    end
  end
endmodule

module pending_priority_encoder #(
  parameter  int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         clr_all,
  output logic [W-1:0] y,
  output logic         y_valid,
  input  logic         y_ready,
  output logic [N-1:0] pending,
  output logic [N-1:0] overflow
);
  typedef enum logic {IDLE, OFFER} state_t;

  state_t       state, state_nx;
  logic [W-1:0] y_nx;
  logic [W-1:0] pick;
  logic [N-1:0] grant;
  logic [N-1:0] pend_nx;
  logic         fire;

  assign y_valid = (state == OFFER);
  assign fire    = y_valid & y_ready;

  for (genvar i = 0; i < N; i++) begin : g_grant
    assign grant[i] = fire && (y == W'(i));
  end

  pend_lane u_lane [N-1:0] (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant    (grant),
    .clr      (clr_all),
    .pending  (pending),
    .overflow (overflow),
    .pend_nx  (pend_nx)
  );

`ifdef PENC_ROUND_ROBIN_EN
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_eff;
  logic [W-1:0] cand;

  // Search from the index just granted so a same-cycle re-request goes last.
  assign ptr_eff = fire ? y : ptr;

  always_comb begin
    pick = '0;
    cand = '0;
    for (int k = N; k >= 1; k--) begin
      cand = W'((int'(ptr_eff) + N - k) % N);
      if (pend_nx[cand]) pick = cand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= '0;
    else if (clr_all) ptr <= '0;
    else if (fire)    ptr <= y;
  end
`else
  always_comb begin
    pick = '0;
    for (int i = 0; i < N; i++)
      if (pend_nx[i]) pick = W'(i);
  end
`endif

  always_comb begin
    state_nx = state;
    y_nx     = y;
    unique case (state)
      IDLE: begin
        if (|pend_nx) begin
          state_nx = OFFER;
          y_nx     = pick;
        end
      end
      OFFER: begin
        if (fire) begin
          if (|pend_nx) y_nx = pick;
          else          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (clr_all) begin
      state_nx = IDLE;
      y_nx     = y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      y     <= '0;
    end else begin
      state <= state_nx;
      y     <= y_nx;
    end
  end
endmodule
